// File: rtl/bcd_digit_feeder.sv
// bcd_digit_feeder: captures an 8-bit PC and an 8-bit register value on a
// load strobe and converts both to decimal tens/units digits using a
// shift-add-3 (double-dabble) engine. All digits commit atomically.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   load       conversion request, honoured only in IDLE
//   pc_bin     program counter value (unsigned, 8 bits)
//   reg_bin    register value (unsigned, 8 bits)
//   pc1/pc2    PC tens/units digit (4'hF each when value >= 100)
//   regpart1/2 register tens/units digit (4'hF each when value >= 100)
//   final_cnt  commit counter 0-9, wraps decimally; drives the
//              display driver's "final" input
//   estado     FSM state code (0 idle, 1 convert, 2 commit)
//   busy       high while a conversion is in flight
//   done       one-cycle pulse after a commit
module bcd_digit_feeder (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] pc_bin,
    input  logic [7:0] reg_bin,
    output logic [3:0] pc1,
    output logic [3:0] pc2,
    output logic [3:0] regpart1,
    output logic [3:0] regpart2,
    output logic [3:0] final_cnt,
    output logic [3:0] estado,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        CONVERT = 4'd1,
        COMMIT  = 4'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [19:0] pc_sr;
    logic [19:0] reg_sr;
    logic [2:0]  iter;

    // One double-dabble step: {hundreds, tens, units, binary}.
    // Nibbles >= 5 get +3 so the following shift carries correctly.
    function automatic logic [19:0] dabble(input logic [19:0] s);
        logic [19:0] a;
        a = s;
        if (a[11:8] >= 4'd5)
            a[11:8] = a[11:8] + 4'd3;
        if (a[15:12] >= 4'd5)
            a[15:12] = a[15:12] + 4'd3;
        if (a[19:16] >= 4'd5)
            a[19:16] = a[19:16] + 4'd3;
        return {a[18:0], 1'b0};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = CONVERT;
            CONVERT: if (iter == 3'd7) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_sr     <= '0;
            reg_sr    <= '0;
            iter      <= '0;
            pc1       <= '0;
            pc2       <= '0;
            regpart1  <= '0;
            regpart2  <= '0;
            final_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        pc_sr  <= {12'd0, pc_bin};
                        reg_sr <= {12'd0, reg_bin};
                        iter   <= '0;
                    end
                end
                CONVERT: begin
                    pc_sr  <= dabble(pc_sr);
                    reg_sr <= dabble(reg_sr);
                    iter   <= iter + 3'd1;
                end
                COMMIT: begin
                    // A non-zero hundreds nibble blanks both digits.
                    if (pc_sr[19:16] == 4'd0) begin
                        pc1 <= pc_sr[15:12];
                        pc2 <= pc_sr[11:8];
                    end else begin
                        pc1 <= 4'hF;
                        pc2 <= 4'hF;
                    end
                    if (reg_sr[19:16] == 4'd0) begin
                        regpart1 <= reg_sr[15:12];
                        regpart2 <= reg_sr[11:8];
                    end else begin
                        regpart1 <= 4'hF;
                        regpart2 <= 4'hF;
                    end
                    if (final_cnt == 4'd9)
                        final_cnt <= 4'd0;
                    else
                        final_cnt <= final_cnt + 4'd1;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign estado = state;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_bcd_digit_feeder.sv
// Testbench for bcd_digit_feeder: table-driven conversions plus directed
// multi-cycle sequences (ignored load, back-to-back, wrap, resets).
module tb_bcd_digit_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] pc_bin;
    logic [7:0] reg_bin;
    logic [3:0] pc1;
    logic [3:0] pc2;
    logic [3:0] regpart1;
    logic [3:0] regpart2;
    logic [3:0] final_cnt;
    logic [3:0] estado;
    logic       busy;
    logic       done;

    bcd_digit_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .pc_bin    (pc_bin),
        .reg_bin   (reg_bin),
        .pc1       (pc1),
        .pc2       (pc2),
        .regpart1  (regpart1),
        .regpart2  (regpart2),
        .final_cnt (final_cnt),
        .estado    (estado),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] rg;
        logic [3:0] e1;
        logic [3:0] e2;
        logic [3:0] e3;
        logic [3:0] e4;
    } vec_t;

    vec_t       vt[6];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [3:0] exp_final;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic bump_final();
        exp_final = (exp_final == 4'd9) ? 4'd0 : exp_final + 4'd1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b0;
        @(negedge clk);
        chk("reset_outs", {pc1, pc2, regpart1, regpart2, final_cnt, estado},
            24'h0);
        chk("reset_busy_done", {busy, done}, 2'b00);
        reset = 1'b0;
        exp_final = 4'd0;
    endtask

    // Single conversion with a one-cycle load; checks latency, busy length,
    // estado sequence, digit hold, result, counter and done pulse width.
    task automatic run_conv(input logic [7:0] pc, input logic [7:0] rg,
                            input logic [3:0] e1, input logic [3:0] e2,
                            input logic [3:0] e3, input logic [3:0] e4);
        int          cyc;
        int          bcnt;
        bit          seq_ok;
        bit          hold_ok;
        logic [19:0] prev;
        prev = {pc1, pc2, regpart1, regpart2, final_cnt};
        @(negedge clk);
        pc_bin  = pc;
        reg_bin = rg;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        pc_bin  = ~pc;
        reg_bin = ~rg;
        cyc = 0;
        bcnt = 0;
        seq_ok = 1'b1;
        hold_ok = 1'b1;
        while (!done && cyc < 20) begin
            if (busy) bcnt++;
            if (busy !== (estado != 4'd0)) seq_ok = 1'b0;
            if (cyc < 8 && estado !== 4'd1) seq_ok = 1'b0;
            if (cyc == 8 && estado !== 4'd2) seq_ok = 1'b0;
            if ({pc1, pc2, regpart1, regpart2, final_cnt} !== prev)
                hold_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        bump_final();
        chk("done_latency", cyc, 9);
        chk("busy_cycles", bcnt, 9);
        chk("estado_seq", seq_ok, 1);
        chk("digit_hold", hold_ok, 1);
        chk("digits", {pc1, pc2, regpart1, regpart2}, {e1, e2, e3, e4});
        chk("final", final_cnt, exp_final);
        chk("idle_after", {estado, busy}, 5'd0);
        @(negedge clk);
        chk("done_fall", done, 0);
    endtask

    initial begin
        int          cyc;
        int          ndone;
        logic [15:0] got;

        vt[0] = '{8'd42,  8'd7,   4'd4, 4'd2, 4'd0, 4'd7};
        vt[1] = '{8'd99,  8'd0,   4'd9, 4'd9, 4'd0, 4'd0};
        vt[2] = '{8'd100, 8'd255, 4'hF, 4'hF, 4'hF, 4'hF};
        vt[3] = '{8'd0,   8'd99,  4'd0, 4'd0, 4'd9, 4'd9};
        vt[4] = '{8'd255, 8'd63,  4'hF, 4'hF, 4'd6, 4'd3};
        vt[5] = '{8'd5,   8'd50,  4'd0, 4'd5, 4'd5, 4'd0};

        reset   = 1'b1;
        load    = 1'b0;
        pc_bin  = 8'd0;
        reg_bin = 8'd0;
        exp_final = 4'd0;
        do_reset();

        for (int i = 0; i < 6; i++)
            run_conv(vt[i].pc, vt[i].rg, vt[i].e1, vt[i].e2,
                     vt[i].e3, vt[i].e4);

        // load during CONVERT is ignored; input change does not matter
        @(negedge clk);
        pc_bin = 8'd15;
        reg_bin = 8'd3;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        load = 1'b1;
        pc_bin = 8'd88;
        @(negedge clk);
        load = 1'b0;
        ndone = 0;
        got = '0;
        for (int i = 0; i < 25; i++) begin
            if (done) begin
                ndone++;
                got = {pc1, pc2, regpart1, regpart2};
            end
            @(negedge clk);
        end
        bump_final();
        chk("ign_done_count", ndone, 1);
        chk("ign_digits", got, 16'h1503);
        chk("ign_final", final_cnt, exp_final);
        chk("ign_idle", estado, 0);

        // back-to-back with load held high
        @(negedge clk);
        pc_bin = 8'd21;
        reg_bin = 8'd34;
        load = 1'b1;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        bump_final();
        chk("b2b_lat1", cyc, 10);
        chk("b2b_digits1", {pc1, pc2, regpart1, regpart2}, 16'h2134);
        chk("b2b_final1", final_cnt, exp_final);
        @(negedge clk);
        chk("b2b_restart", {done, busy, estado}, 6'b01_0001);
        load = 1'b0;
        pc_bin = 8'd0;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        bump_final();
        chk("b2b_lat2", cyc, 9);
        chk("b2b_digits2", {pc1, pc2, regpart1, regpart2}, 16'h2134);
        chk("b2b_final2", final_cnt, exp_final);

        // commit counter wrap
        do_reset();
        for (int k = 0; k < 10; k++)
            run_conv(8'd10 + 8'(k), 8'd0, 4'd1, 4'(k), 4'd0, 4'd0);
        chk("wrap_zero", final_cnt, 0);

        // reset mid-conversion
        @(negedge clk);
        pc_bin = 8'd63;
        reg_bin = 8'd5;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_digits", {pc1, pc2, regpart1, regpart2}, 16'h0);
        chk("mid_rst_state", {final_cnt, estado, busy}, 9'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_final = 4'd0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("mid_rst_nodone", ndone, 0);
        chk("mid_rst_idle", estado, 0);
        run_conv(8'd63, 8'd5, 4'd6, 4'd3, 4'd0, 4'd5);

        // reset during COMMIT wins
        @(negedge clk);
        pc_bin = 8'd77;
        reg_bin = 8'd88;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cyc = 0;
        while (estado !== 4'd2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("commit_reached", estado, 2);
        reset = 1'b1;
        @(negedge clk);
        chk("commit_rst_digits", {pc1, pc2, regpart1, regpart2}, 16'h0);
        chk("commit_rst_state", {final_cnt, estado, busy, done}, 10'd0);
        reset = 1'b0;
        exp_final = 4'd0;
        @(negedge clk);
        chk("commit_rst_nodone", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
